// File: rtl/bitwise_logic_pipe_if.sv
// rtl/bitwise_logic_pipe_if.sv - operand/result handshake bundle for bitwise_logic_pipe
// stat_count is present only when BITWISE_LOGIC_PIPE_STATS_EN is defined.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] ones;
    logic             zero;
    logic             all_ones;
`ifdef BITWISE_LOGIC_PIPE_STATS_EN
    logic [15:0]      stat_count;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, ones, zero, all_ones, stat_count
    );
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, ones, zero, all_ones, stat_count
    );
`else
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, ones, zero, all_ones
    );
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, ones, zero, all_ones
    );
`endif
endinterface

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - two-stage bitwise logic unit with popcount/zero/all-ones flags
// Optional transfer counter on stat_count when BITWISE_LOGIC_PIPE_STATS_EN is defined.
module bitwise_logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitwise_logic_pipe_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_y;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_y;
    logic [CNT_W-1:0] r_s2_ones;
    logic             r_s2_zero;
    logic             r_s2_all_ones;

    logic             w_s1_en;
    logic             w_s2_en;
    logic [WIDTH-1:0] w_f;
    logic [CNT_W-1:0] w_pop;

    assign w_s2_en = !r_s2_valid || bus.out_ready;
    assign w_s1_en = !r_s1_valid || w_s2_en;

    always_comb begin
        w_f = bus.a;
        case (bus.op)
            3'b000:  w_f = bus.a & bus.b;
            3'b001:  w_f = bus.a | bus.b;
            3'b010:  w_f = bus.a ^ bus.b;
            3'b011:  w_f = ~(bus.a ^ bus.b);
            3'b100:  w_f = ~(bus.a & bus.b);
            3'b101:  w_f = ~(bus.a | bus.b);
            3'b110:  w_f = ~bus.a;
            default: w_f = bus.a;
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + CNT_W'(r_s1_y[i]);
        end
    end

    // Data registers only load alongside a valid, so bubbles leave them stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_y     <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_y <= w_f;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_y        <= '0;
            r_s2_ones     <= '0;
            r_s2_zero     <= 1'b0;
            r_s2_all_ones <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y        <= r_s1_y;
                r_s2_ones     <= w_pop;
                r_s2_zero     <= (r_s1_y == '0);
                r_s2_all_ones <= &r_s1_y;
            end
        end
    end

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_s2_valid;
    assign bus.y         = r_s2_y;
    assign bus.ones      = r_s2_ones;
    assign bus.zero      = r_s2_zero;
    assign bus.all_ones  = r_s2_all_ones;

`ifdef BITWISE_LOGIC_PIPE_STATS_EN
    logic [15:0] r_stat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_count <= '0;
        end else if (r_s2_valid && bus.out_ready) begin
            r_stat_count <= r_stat_count + 16'd1;
        end
    end

    assign bus.stat_count = r_stat_count;
`endif
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - self-checking bench for bitwise_logic_pipe
module tb_bitwise_logic_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bitwise_logic_pipe_if #(.WIDTH(W)) bus ();
    bitwise_logic_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] y;
        int           cyc;
    } exp_t;

    localparam logic [7:0] LIT_Y    [8] = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};
    localparam int         LIT_ONES [8] = '{2, 6, 4, 4, 6, 2, 4, 4};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   strict_lat = 1'b0;
    exp_t q[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z, input logic [2:0] op);
        case (op)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x ^ z);
            3'd4:    return ~(x & z);
            3'd5:    return ~(x | z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Occupancy is the scoreboard depth; every cycle with out_valid is checked against its head.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 || bus.out_ready));
            if (bus.out_valid) begin
                chk("out_has_pending", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q[0];
                    chk("y", 32'(bus.y), 32'(e.y));
                    chk("ones", 32'(bus.ones), 32'($countones(e.y)));
                    chk("zero", 32'(bus.zero), 32'(e.y == '0));
                    chk("all_ones", 32'(bus.all_ones), 32'(e.y == '1));
                    if (strict_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{model(bus.a, bus.b, bus.op), cyc});
                n_acc++;
            end
        end
    end

    task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic [2:0] op_i);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.a  = a_i;
        bus.b  = b_i;
        bus.op = op_i;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("send_timeout", 32'(guard), 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0 || bus.out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int base_acc;
    int base_out;
    int base_cyc;

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_ones", 32'(bus.ones), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        strict_lat = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(8'hA5, 8'h0F, 3'(k));
            @(posedge clk);
            #1;
            chk("sweep_valid", 32'(bus.out_valid), 32'd1);
            chk("sweep_y", 32'(bus.y), 32'(LIT_Y[k]));
            chk("sweep_ones", 32'(bus.ones), 32'(LIT_ONES[k]));
        end
        drain();

        send(8'h3C, 8'h3C, 3'd3);
        @(posedge clk);
        #1;
        chk("eq_y", 32'(bus.y), 32'hFF);
        chk("eq_ones", 32'(bus.ones), 32'd8);
        chk("eq_all_ones", 32'(bus.all_ones), 32'd1);
        chk("eq_zero", 32'(bus.zero), 32'd0);
        send(8'h00, 8'hFF, 3'd3);
        @(posedge clk);
        #1;
        chk("ne_y", 32'(bus.y), 32'h00);
        chk("ne_zero", 32'(bus.zero), 32'd1);
        chk("ne_ones", 32'(bus.ones), 32'd0);
        drain();

        strict_lat = 1'b0;
        bus.out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_accepts", 32'(n_acc - base_acc), 32'd2);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", 32'(n_out - base_out), 32'd5);

        strict_lat = 1'b1;
        base_out = n_out;
        base_cyc = cyc;
        for (int i = 0; i < 20; i++) send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        chk("fullrate_cycles", 32'(cyc - base_cyc), 32'd20);
        drain();
        chk("fullrate_delivered", 32'(n_out - base_out), 32'd20);

        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 3'd1);
        send(8'h56, 8'h78, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_y", 32'(bus.y), 32'd0);
        chk("midrst_ones", 32'(bus.ones), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        base_out = n_out;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("postrst_no_output", 32'(n_out - base_out), 32'd0);

`ifdef BITWISE_LOGIC_PIPE_STATS_EN
        rst_n = 1'b0;
        #1;
        chk("stat_reset", 32'(bus.stat_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_out = n_out;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            bus.op = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();
        chk("stat_count_model", 32'(bus.stat_count), 32'((n_out - base_out) % 65536));
        chk("stat_count", 32'(bus.stat_count), 32'd4464);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
